bus_prefetch_queue: RTL and testbench
=====================================

Name: bus_prefetch_queue

Overview:
- Sits between the CPU bus master and the memory target, on the same toggle-handshake bus (run/done toggle, cmd nop=2'b00, read=2'b01, write=2'b10).
- Speculatively reads sequential words ahead of the last CPU read into a small queue.
- Serves in-order instruction fetches in 1 clock instead of a full memory round trip.
- Forwards non-sequential reads and all writes to memory, then flushes the queue.

Parameters:
DEPTH, 4, queue entries; power of two, >=2
ADDR_W, 16, byte address width; bit 0 ignored (word aligned)
DATA_W, 16, word width

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
cpu_addr  in  ADDR_W  CPU request byte address
cpu_cmd  in  2  CPU command (nop/read/write)
cpu_run  in  1  CPU request toggle; request pending while cpu_run != cpu_done
cpu_wr_data  in  DATA_W  CPU write data
cpu_rd_data  out  DATA_W  read data; valid when cpu_done toggles
cpu_done  out  1  CPU completion toggle
mem_addr  out  ADDR_W  memory request address
mem_cmd  out  2  memory command
mem_run  out  1  memory request toggle
mem_wr_data  out  DATA_W  memory write data
mem_rd_data  in  DATA_W  memory read data; valid once mem_done == mem_run
mem_done  in  1  memory completion toggle
pf_count  out  $clog2(DEPTH+1)  number of valid queue entries

Behaviour:
- Reset: all outputs 0 (mem_cmd = nop); count=0, head_addr=0, pf_en=0, drop=0; state IDLE. Reset mid-transaction abandons it. The CPU and memory peers are reset together.
- Queue: entry i holds mem[head_addr + 2i]. Next prefetch address = head_addr + 2*count, mod 2^ADDR_W (FFFEh+2 wraps to 0000h). Address compares use addr[ADDR_W-1:1].
- mem_busy = mem_run != mem_done. mem_cmd, mem_addr and mem_wr_data stay stable while mem_busy. The block has at most one outstanding memory request.
- States:
  - IDLE: accepts new CPU requests.
  - DEMAND: a forwarded CPU read or write is in flight.
  - WAIT_MEM: a demand is queued behind an in-flight prefetch.
- Hit (IDLE, cmd=read, count>0, addr==head_addr):
  - Next edge: cpu_rd_data = entry[0], cpu_done toggles (latency 1 clock).
  - Pop: head_addr += 2, count -= 1.
- Hit-pending (count==0, a prefetch of head_addr in flight, addr==head_addr): wait for the fill, then serve as a hit on the following edge.
- Miss read:
  - Flush: count=0. If a prefetch is in flight, set drop=1 and discard its data on arrival.
  - When mem is idle, issue the read. On mem_done toggle: cpu_rd_data = mem_rd_data, cpu_done toggles, head_addr = addr+2, pf_en=1.
- Write: flush as for a miss, forward the write, toggle cpu_done on memory completion, pf_en=0 until the next CPU read.
- Nop with a toggle: cpu_done toggles next edge; no other effect.
- Prefetch issue: IDLE, pf_en, count<DEPTH, mem idle, no pending CPU request (a CPU request always wins). Issue a read of the next prefetch address. On completion, push unless drop (drop then clears).
- Simultaneous pop and push in one edge: count unchanged; the pushed entry lands at the correct slot.
- Full (count==DEPTH): no prefetch issued. Empty: only the demand or hit-pending paths serve reads.

Test Plan:
- Reset low mid-prefetch, then release → all outputs 0, pf_count=0; first read of 0000h goes to memory as a demand.
- Read 0000h (demand), then reads 0002h, 0004h, 0006h, 0008h after the queue fills → each served 1 clock after the cpu_run toggle with the correct data; pf_count refills toward 4.
- Sequential reads, then read 0010h while queue holds 0008h–000Eh → flush; the in-flight prefetch's data is dropped; cpu_rd_data = mem[0010h]; the queue restarts at 0012h.
- Write 1234h to 0020h with the queue full → mem_cmd=write, pf_count=0, no prefetch until the next read; a later read of 0020h returns 1234h.
- Read FFFCh with a memory that takes 3 clocks per request → prefetches FFFEh then 0000h, 0002h; sequential reads FFFEh and 0000h hit.
- Pop and fill on the same edge with count=2 → pf_count stays 2; subsequent hits return data in address order.

Source files
------------

// File: rtl/bus_prefetch_queue_if.sv
// Toggle-handshake bus: a request is pending while run != done.
// The requester drives the master modport, the responder the slave modport.
interface bus_prefetch_queue_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] addr;
    logic [1:0]        cmd;
    logic              run;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              done;

    modport master (output addr, cmd, run, wr_data, input rd_data, done);
    modport slave  (input addr, cmd, run, wr_data, output rd_data, done);
endinterface

// File: rtl/bus_prefetch_queue.sv
// Sequential read-ahead queue between a CPU bus master and a memory target.
// In-order reads hit the queue in one clock; anything else goes to memory and flushes it.
module bus_prefetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    bus_prefetch_queue_if.slave        cpu,
    bus_prefetch_queue_if.master       mem,
    output logic [$clog2(DEPTH+1)-1:0] pf_count
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WA_W  = ADDR_W - 1;
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {IDLE, DEMAND, WAIT_MEM} state_t;
    state_t state, state_n;

    logic [DATA_W-1:0] q_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WA_W-1:0]   head_w;
    logic              pf_en;
    logic              drop;
    logic              mem_out;
    logic              mem_is_pf;
    logic              cpu_done_q;
    logic [DATA_W-1:0] cpu_rd_data_q;
    logic              mem_run_q;
    logic [1:0]        mem_cmd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wr_data_q;

    logic              cpu_pending, mem_busy, mem_cpl;
    logic [ADDR_W-1:0] req_addr;
    logic              rd_req, wr_req, addr_hit, pf_to_head, hit_ok, hit_wait;
    logic              hit, nop_ack, flush, issue_dem, dem_done, push, issue_pf;
    logic [CNT_W-1:0]  count_after;
    logic [WA_W-1:0]   pf_addr_w;

    assign cpu_pending = cpu.run != cpu_done_q;
    assign mem_busy    = mem_run_q != mem.done;
    assign mem_cpl     = mem_out && !mem_busy;
    assign req_addr    = cpu.addr & ~ADDR_W'(1);
    assign rd_req      = cpu.cmd == CMD_READ;
    assign wr_req      = cpu.cmd == CMD_WRITE;
    assign addr_hit    = req_addr[ADDR_W-1:1] == head_w;
    // An undropped prefetch for the head word will fill the empty queue shortly.
    assign pf_to_head  = mem_out && mem_is_pf && !drop && (mem_addr_q[ADDR_W-1:1] == head_w);
    assign hit_ok      = rd_req && addr_hit && (count != '0);
    assign hit_wait    = rd_req && addr_hit && (count == '0) && pf_to_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        hit       = 1'b0;
        nop_ack   = 1'b0;
        flush     = 1'b0;
        issue_dem = 1'b0;
        dem_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_pending) begin
                    if (hit_ok) begin
                        hit = 1'b1;
                    end else if (hit_wait) begin
                        state_n = IDLE;
                    end else if (rd_req || wr_req) begin
                        flush = 1'b1;
                        if (!mem_busy) begin
                            issue_dem = 1'b1;
                            state_n   = DEMAND;
                        end else begin
                            state_n = WAIT_MEM;
                        end
                    end else begin
                        nop_ack = 1'b1;
                    end
                end
            end
            DEMAND: begin
                if (mem_cpl) begin
                    dem_done = 1'b1;
                    state_n  = IDLE;
                end
            end
            WAIT_MEM: begin
                if (!mem_busy) begin
                    issue_dem = 1'b1;
                    state_n   = DEMAND;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign push = mem_cpl && mem_is_pf && !drop && !flush;

    always_comb begin
        count_after = count;
        if (flush)             count_after = '0;
        else if (push && !hit) count_after = count + 1'b1;
        else if (hit && !push) count_after = count - 1'b1;
    end

    // Prefetch only when the CPU is quiet; the address accounts for a fill landing this edge.
    assign pf_addr_w = head_w + WA_W'(count_after);
    assign issue_pf  = (state == IDLE) && !cpu_pending && pf_en && !mem_busy
                       && (count_after < CNT_W'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr        <= '0;
            count         <= '0;
            head_w        <= '0;
            pf_en         <= 1'b0;
            drop          <= 1'b0;
            mem_out       <= 1'b0;
            mem_is_pf     <= 1'b0;
            cpu_done_q    <= 1'b0;
            cpu_rd_data_q <= '0;
            mem_run_q     <= 1'b0;
            mem_cmd_q     <= CMD_NOP;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
        end else begin
            count <= count_after;
            if (hit) rd_ptr <= rd_ptr + 1'b1;

            if (hit)
                head_w <= head_w + 1'b1;
            else if (dem_done && mem_cmd_q == CMD_READ)
                head_w <= mem_addr_q[ADDR_W-1:1] + 1'b1;

            if (dem_done) pf_en <= (mem_cmd_q == CMD_READ);

            if (mem_cpl && mem_is_pf)
                drop <= 1'b0;
            else if (flush && mem_out && mem_is_pf)
                drop <= 1'b1;

            if (hit) begin
                cpu_rd_data_q <= q_mem[rd_ptr];
                cpu_done_q    <= ~cpu_done_q;
            end else if (nop_ack) begin
                cpu_done_q <= ~cpu_done_q;
            end else if (dem_done) begin
                cpu_done_q <= ~cpu_done_q;
                if (mem_cmd_q == CMD_READ) cpu_rd_data_q <= mem.rd_data;
            end

            if (issue_dem) begin
                mem_run_q     <= ~mem_run_q;
                mem_cmd_q     <= cpu.cmd;
                mem_addr_q    <= req_addr;
                mem_wr_data_q <= cpu.wr_data;
            end else if (issue_pf) begin
                mem_run_q  <= ~mem_run_q;
                mem_cmd_q  <= CMD_READ;
                mem_addr_q <= {pf_addr_w, 1'b0};
            end

            if (issue_dem || issue_pf) begin
                mem_out   <= 1'b1;
                mem_is_pf <= issue_pf;
            end else if (mem_cpl) begin
                mem_out <= 1'b0;
            end
        end
    end

    // Entry storage is pure data and needs no reset; the slot is rd_ptr + count mod DEPTH.
    always_ff @(posedge clk) begin
        if (push) q_mem[rd_ptr + PTR_W'(count)] <= mem.rd_data;
    end

    assign cpu.done    = cpu_done_q;
    assign cpu.rd_data = cpu_rd_data_q;
    assign mem.run     = mem_run_q;
    assign mem.cmd     = mem_cmd_q;
    assign mem.addr    = mem_addr_q;
    assign mem.wr_data = mem_wr_data_q;
    assign pf_count    = count;
endmodule

// File: tb/tb_bus_prefetch_queue.sv
// Scoreboard bench for bus_prefetch_queue: a toggle-bus memory slave, a CPU driver
// that predicts read data from a shadow memory, and a monitor comparing completions.
module tb_bus_prefetch_queue;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] pf_count;

    bus_prefetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cpu ();
    bus_prefetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem ();

    bus_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .cpu(cpu), .mem(mem), .pf_count(pf_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem_arr [32768];
    logic [15:0] shadow  [32768];
    int          tests = 0;
    int          fails = 0;
    int          mem_lat = 2;
    int          mem_reqs = 0;
    logic [1:0]  last_cmd = 2'b00;
    logic [15:0] last_addr = 16'h0;
    int          last_lat = 0;

    function automatic logic [15:0] init_word(input int w);
        return 16'(w * 40503 + 4660);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Memory target: responds mem_lat negedges after seeing a new request.
    initial begin
        logic [15:0] a, w;
        logic [1:0]  c;
        bit          aborted, stable;
        mem.done = 1'b0;
        mem.rd_data = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mem.done = 1'b0;
                mem.rd_data = '0;
            end else if (mem.run != mem.done) begin
                a = mem.addr; c = mem.cmd; w = mem.wr_data;
                mem_reqs++; last_cmd = c; last_addr = a;
                aborted = 1'b0;
                stable = (c == RD) || (c == WR);
                for (int i = 1; i < mem_lat; i++) begin
                    @(negedge clk);
                    if (!reset) aborted = 1'b1;
                    else if (mem.addr !== a || mem.cmd !== c || mem.wr_data !== w) stable = 1'b0;
                end
                if (aborted || !reset) begin
                    mem.done = 1'b0;
                    mem.rd_data = '0;
                end else begin
                    check("mem_req_stable", stable, 1);
                    if (c == WR) mem_arr[a[15:1]] = w;
                    else         mem.rd_data = mem_arr[a[15:1]];
                    mem.done = mem.run;
                end
            end
        end
    end

    // Completion monitor: pops one expectation per cpu.done toggle.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b0;
            end else if (cpu.done != prev) begin
                prev = cpu.done;
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_done: got a completion, required none pending");
                end else begin
                    e = sb.pop_front();
                    if (e.cmd == RD)
                        check($sformatf("rd_data_%04h", e.addr), cpu.rd_data, e.data);
                end
            end
        end
    end

    task automatic cpu_op(input logic [1:0] c, input logic [15:0] a, input logic [15:0] w);
        exp_t e;
        int   n;
        e.cmd = c; e.addr = a;
        e.data = (c == RD) ? shadow[a[15:1]] : w;
        if (c == WR) shadow[a[15:1]] = w;
        sb.push_back(e);
        cpu.addr = a; cpu.cmd = c; cpu.wr_data = w;
        cpu.run = ~cpu.run;
        n = 0;
        while (cpu.done != cpu.run && n < 200) begin
            @(negedge clk);
            n++;
        end
        last_lat = n;
        check("cpu_done_in_time", cpu.done == cpu.run, 1);
    endtask

    task automatic wait_count(input int n, input string name);
        int k;
        k = 0;
        while (pf_count != n && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, pf_count, n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, k, n0, n1;
        logic [15:0] next_addr, a;
        cpu.addr = '0; cpu.cmd = NOP; cpu.run = 1'b0; cpu.wr_data = '0;
        for (int i = 0; i < 32768; i++) begin
            mem_arr[i] = init_word(i);
            shadow[i]  = init_word(i);
        end
        idle(3);
        reset = 1'b1;
        idle(1);

        // Start prefetching, then reset while a prefetch is outstanding.
        cpu_op(RD, 16'h0000, 16'h0);
        k = 0;
        while (mem.run == mem.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rst_mid_pf_busy", mem.run != mem.done, 1);
        reset = 1'b0;
        cpu.run = 1'b0; cpu.cmd = NOP; cpu.addr = '0; cpu.wr_data = '0;
        idle(1);
        check("rst_cpu_done", cpu.done, 0);
        check("rst_cpu_rd_data", cpu.rd_data, 0);
        check("rst_mem_run", mem.run, 0);
        check("rst_mem_cmd", mem.cmd, 0);
        check("rst_mem_addr", mem.addr, 0);
        check("rst_mem_wr_data", mem.wr_data, 0);
        check("rst_pf_count", pf_count, 0);
        idle(1);
        reset = 1'b1;
        idle(1);

        mem_lat = 1;
        n0 = mem_reqs;
        cpu_op(RD, 16'h0000, 16'h0);
        check("rst_demand_lat", last_lat > 1, 1);
        check("rst_demand_reqs", mem_reqs - n0, 1);
        check("rst_demand_addr", last_addr, 16'h0000);

        // Sequential hits once the queue is full.
        for (int i = 1; i <= 3; i++) begin
            wait_count(DEPTH, "seq_fill");
            cpu_op(RD, 16'(2 * i), 16'h0);
            check("seq_hit_lat", last_lat, 1);
        end

        // Queue holds 0008..000E; hit 0008, let the 0010 prefetch start, then miss on 0010.
        mem_lat = 3;
        wait_count(DEPTH, "flush_fill");
        cpu_op(RD, 16'h0008, 16'h0);
        check("flush_pre_hit_lat", last_lat, 1);
        idle(1);
        check("flush_pf_inflight", mem.run != mem.done, 1);
        cpu_op(RD, 16'h0010, 16'h0);
        check("flush_cnt", pf_count, 0);
        wait_count(DEPTH, "flush_refill");
        cpu_op(RD, 16'h0012, 16'h0);
        check("flush_restart_lat", last_lat, 1);

        // Write with a full queue.
        mem_lat = 1;
        wait_count(DEPTH, "wr_fill");
        cpu_op(WR, 16'h0020, 16'h1234);
        check("wr_mem_cmd", last_cmd, WR);
        check("wr_mem_addr", last_addr, 16'h0020);
        check("wr_flush_cnt", pf_count, 0);
        n1 = mem_reqs;
        idle(10);
        check("wr_no_prefetch", mem_reqs, n1);
        cpu_op(RD, 16'h0020, 16'h0);
        check("wr_readback", cpu.rd_data, 16'h1234);
        cpu_op(NOP, 16'h0, 16'h0);
        check("nop_lat", last_lat, 1);

        // Address wrap with a slow memory.
        mem_lat = 3;
        cpu_op(RD, 16'hFFFC, 16'h0);
        wait_count(DEPTH, "wrap_fill");
        cpu_op(RD, 16'hFFFE, 16'h0);
        check("wrap_hit_fffe_lat", last_lat, 1);
        cpu_op(RD, 16'h0000, 16'h0);
        check("wrap_hit_0000_lat", last_lat, 1);

        // Hit-pending: next read arrives while its prefetch is in flight.
        cpu_op(RD, 16'h0100, 16'h0);
        idle(1);
        cpu_op(RD, 16'h0102, 16'h0);
        check("hit_pend_lat", last_lat, 4);

        // Pop and fill on the same edge at count 2.
        mem_lat = 1;
        cpu_op(RD, 16'h0200, 16'h0);
        wait_count(2, "pp_two");
        cpu_op(RD, 16'h0202, 16'h0);
        check("pp_hit_lat", last_lat, 1);
        check("pp_cnt", pf_count, 2);
        cpu_op(RD, 16'h0204, 16'h0);
        check("pp_hit2_lat", last_lat, 1);
        cpu_op(RD, 16'h0206, 16'h0);
        check("pp_hit3_lat", last_lat, 1);

        // Randomized mix over a small window so writes are read back.
        next_addr = 16'h0300;
        for (int t = 0; t < 200; t++) begin
            mem_lat = $urandom_range(1, 3);
            r = $urandom_range(0, 9);
            if (r < 5) begin
                cpu_op(RD, next_addr, 16'h0);
                next_addr = {next_addr[15:1], 1'b0} + 16'h2;
            end else if (r < 7) begin
                a = 16'h0300 + 16'($urandom_range(0, 127));
                cpu_op(RD, a, 16'h0);
                next_addr = {a[15:1], 1'b0} + 16'h2;
            end else if (r < 9) begin
                a = 16'h0300 + 16'($urandom_range(0, 127));
                cpu_op(WR, a, 16'($urandom));
            end else begin
                cpu_op(NOP, 16'h0, 16'h0);
            end
            idle($urandom_range(0, 3));
        end

        idle(20);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
